// File: rtl/pwp_activation_pkg.sv
// act_pkg: Q.11 segment coefficients, thresholds, enums and the saturation helper for pwp_activation.
package act_pkg;
    localparam int ONE_Q11 = 2048;
    localparam int TH_B = 6144;
    localparam int TH_C = 12288;
    localparam int P0_A = 1020, P1_A = 558, P2_A = -83;
    localparam int P0_B = 1632, P1_B = 147, P2_B = -13;
    localparam int P0_C = 2048, P1_C = 0, P2_C = 0;
    typedef enum logic {ACT_SIGMOID, ACT_TANH} mode_t;
    typedef enum logic [2:0] {IDLE, SEG, MUL1, MUL2, DONE} state_t;
    typedef enum logic [1:0] {SEG_A, SEG_B, SEG_C} seg_t;
    function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        return v > hi ? hi : v < -hi - 64'sd1 ? -hi - 64'sd1 : v;
    endfunction
endpackage

// File: rtl/pwp_activation_if.sv
// pwp_activation_if: valid/ready sample and result channels of the activation unit.
interface pwp_activation_if #(parameter int W = 18);
    logic in_valid, in_ready, in_mode, out_valid, out_ready, busy;
    logic signed [W-1:0] in_data, out_data;
    modport master(output in_valid, in_data, in_mode, out_ready, input in_ready, out_valid, out_data, busy);
    modport slave(input in_valid, in_data, in_mode, out_ready, output in_ready, out_valid, out_data, busy);
endinterface

// File: rtl/pwp_coef_rom.sv
// pwp_coef_rom: maps |x| to its segment and the QM-scaled quadratic coefficients.
module pwp_coef_rom import act_pkg::*; #(
    parameter int W = 18,
    parameter int QM = 11
) (
    input logic signed [W-1:0] a,
    output seg_t seg,
    output logic signed [W-1:0] p0,
    output logic signed [W-1:0] p1,
    output logic signed [W-1:0] p2
);
    function automatic logic signed [W-1:0] sc(input int c);
        return W'(longint'(c) <<< (QM - 11));
    endfunction
    always_comb begin
        seg = a < sc(TH_B) ? SEG_A : a < sc(TH_C) ? SEG_B : SEG_C;
        p0 = sc(seg == SEG_A ? P0_A : seg == SEG_B ? P0_B : P0_C);
        p1 = sc(seg == SEG_A ? P1_A : seg == SEG_B ? P1_B : P1_C);
        p2 = sc(seg == SEG_A ? P2_A : seg == SEG_B ? P2_B : P2_C);
    end
endmodule

// File: rtl/pwp_activation.sv
// pwp_activation: piecewise-quadratic sigmoid/tanh on one shared multiplier.
// Define ACT_ROUND_EN for round-half-up on both >>> QM shifts (default truncates).
module pwp_activation import act_pkg::*; #(
    parameter int QN = 6,
    parameter int QM = 11
) (
    input logic clock,
    input logic reset,
    pwp_activation_if.slave io
);
    localparam int W = QN + QM + 1;
    localparam int W2 = 2 * W;
    localparam longint ONE = longint'(ONE_Q11) <<< (QM - 11);
`ifdef ACT_ROUND_EN
    localparam logic signed [W2-1:0] RND = W2'(1) <<< (QM - 1);
`else
    localparam logic signed [W2-1:0] RND = '0;
`endif
    if (QM < 11) begin : g_qm_check
        $error("pwp_activation: QM must be >= 11");
    end
    state_t state;
    mode_t mode_q;
    seg_t seg_c, seg_q;
    logic neg_q, neg_c, out_valid_q;
    logic signed [W-1:0] x_q, a_q, acc_q, p0_q, p1_q, p2_q, out_q;
    logic signed [W-1:0] a_c, p0_c, p1_c, p2_c, r_c;
    logic signed [W2-1:0] ma, mb, prod, sh;
    logic signed [63:0] xe, sum, sn, s;
    pwp_coef_rom #(.W(W), .QM(QM)) u_rom (.a(a_c), .seg(seg_c), .p0(p0_c), .p1(p1_c), .p2(p2_c));
    // tanh(x) = 2*sigmoid(2x) - 1; sigmoid(-a) = 1 - sigmoid(a)
    always_comb begin
        xe = mode_q == ACT_TANH ? sat(64'(x_q) <<< 1, W) : 64'(x_q);
        neg_c = xe[63];
        a_c = W'(sat(neg_c ? -xe : xe, W));
        ma = state == MUL1 ? W2'(p2_q) : W2'(acc_q);
        mb = W2'(a_q);
        prod = ma * mb;
        sh = (prod + RND) >>> QM;
        sum = (seg_q == SEG_C ? '0 : 64'(sh)) + (state == MUL1 ? 64'(p1_q) : 64'(p0_q));
        sn = neg_q ? ONE - sum : sum;
        s = sn[63] ? '0 : sn > ONE ? ONE : sn;
        r_c = W'(mode_q == ACT_TANH ? sat((s <<< 1) - ONE, W) : s);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            out_valid_q <= 1'b0;
            out_q <= '0;
        end else begin
            case (state)
                IDLE: if (io.in_valid) begin
                    x_q <= io.in_data;
                    mode_q <= mode_t'(io.in_mode);
                    state <= SEG;
                end
                SEG: begin
                    a_q <= a_c;
                    neg_q <= neg_c;
                    seg_q <= seg_c;
                    p0_q <= p0_c;
                    p1_q <= p1_c;
                    p2_q <= p2_c;
                    state <= MUL1;
                end
                MUL1: begin
                    acc_q <= W'(sum);
                    state <= MUL2;
                end
                MUL2: begin
                    out_q <= r_c;
                    out_valid_q <= 1'b1;
                    state <= DONE;
                end
                DONE: if (io.out_ready) begin
                    out_valid_q <= 1'b0;
                    x_q <= io.in_data;
                    mode_q <= mode_t'(io.in_mode);
                    state <= io.in_valid ? SEG : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign io.in_ready = state == IDLE || (state == DONE && io.out_ready);
    assign io.out_valid = out_valid_q;
    assign io.out_data = out_q;
    assign io.busy = state != IDLE;
endmodule
